// File: rtl/math_adder_pkg.sv
// Shared definitions for the sequenced math blocks: FSM state encoding and a
// constant-foldable ceil(log2) helper for sizing counters.
package math_adder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // ceil(log2(v)), at least 1 so that counters never collapse to zero width.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/math_adder_ripplecarry.sv
// N-bit ripple-carry adder. s[N] is the carry-out.
module math_adder_ripplecarry #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N:0]   s
);

  logic c;

  // Bit-serial carry chain, LSB first.
  always_comb begin
    s = '0;
    c = ci;
    for (int i = 0; i < int'(N); i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    s[N] = c;
  end

endmodule

// File: rtl/math_adder_multiword_seq.sv
// Multi-precision adder: adds two W*K-bit operands plus carry-in through one
// shared W-bit ripple-carry adder, one chunk per cycle, LSB chunk first.
module math_adder_multiword_seq
  import math_adder_pkg::*;
#(
  parameter int unsigned W = 8,
  parameter int unsigned K = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W*K-1:0]   in_a,
  input  logic [W*K-1:0]   in_b,
  input  logic             in_ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W*K:0]     out_sum,
  output logic             out_ovf,
  output logic             busy
);

  localparam int unsigned N    = W * K;
  localparam int unsigned IdxW = clog2(K);

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [N-1:0]    a_q, a_d, b_q, b_d;
  logic [N:0]      sum_q, sum_d;
  logic            ovf_q, ovf_d;

  logic [W-1:0]    chunk_a, chunk_b;
  logic [W:0]      chunk_s;
  logic            last;

  assign last = (idx_q == IdxW'(K - 1));

  // Select the operand chunks addressed by the chunk index.
  always_comb begin
    chunk_a = '0;
    chunk_b = '0;
    for (int k = 0; k < int'(K); k++) begin
      if (idx_q == IdxW'(k)) begin
        chunk_a = a_q[k*W +: W];
        chunk_b = b_q[k*W +: W];
      end
    end
  end

  math_adder_ripplecarry #(
    .N (W)
  ) u_rca (
    .a  (chunk_a),
    .b  (chunk_b),
    .ci (carry_q),
    .s  (chunk_s)
  );

  // Next-state: operand capture, chunk write-back, carry chain and handshakes.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_ci;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        for (int k = 0; k < int'(K); k++) begin
          if (idx_q == IdxW'(k)) sum_d[k*W +: W] = chunk_s[W-1:0];
        end
        carry_d = chunk_s[W];
        if (last) begin
          // Index stays at K-1; the next accept clears it.
          sum_d[N] = chunk_s[W];
          ovf_d    = (a_q[N-1] == b_q[N-1]) && (chunk_s[W-1] != a_q[N-1]);
          state_d  = StDone;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_sum   = sum_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_math_adder_multiword_seq.sv
// Directed-vector and scoreboard bench for math_adder_multiword_seq,
// W=8/K=4 plus a second W=3/K=5 instance for randomised traffic.
module tb_math_adder_multiword_seq;

  localparam int NR = 2000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic        in_valid = 1'b0, in_ready, in_ci = 1'b0;
  logic [31:0] in_a = '0, in_b = '0;
  logic        out_valid, out_ready = 1'b1, out_ovf, busy;
  logic [32:0] out_sum;

  logic        d1_valid = 1'b0, d1_ready, d1_ci = 1'b0;
  logic [14:0] d1_a = '0, d1_b = '0;
  logic        d1_ovalid, d1_oready = 1'b1, d1_ovf, d1_busy;
  logic [15:0] d1_sum;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  math_adder_multiword_seq #(.W(8), .K(4)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_ci     (in_ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  math_adder_multiword_seq #(.W(3), .K(5)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (d1_valid),
    .in_ready  (d1_ready),
    .in_a      (d1_a),
    .in_b      (d1_b),
    .in_ci     (d1_ci),
    .out_valid (d1_ovalid),
    .out_ready (d1_oready),
    .out_sum   (d1_sum),
    .out_ovf   (d1_ovf),
    .busy      (d1_busy)
  );

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  // One full transaction on dut0 with out_ready held high.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic ci,
                       output logic [32:0] s, output logic o, output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_ci = ci; out_ready = 1'b1;
    check("in_ready before accept", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    // Scramble operands to show the op in flight ignores them.
    in_valid = 1'b0; in_a = ~a; in_b = ~b; in_ci = ~ci;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    s = out_sum;
    o = out_ovf;
    @(posedge clk);
    #1;
  endtask

  // Scoreboards for randomised traffic, sampled mid-cycle on the falling edge.
  logic        rnd_on = 1'b0;
  logic [33:0] q0[$];
  logic [16:0] q1[$];
  int          acc0 = 0, res0 = 0, acc1 = 0, res1 = 0;
  logic [32:0] m0_sum;
  logic [15:0] m1_sum;
  logic [33:0] e0;
  logic [16:0] e1;
  logic        prev_v = 1'b0, prev_r = 1'b0;
  logic [32:0] prev_sum = '0;

  always @(negedge clk) begin
    if (rnd_on) begin
      if (prev_v && !prev_r) begin
        check("rnd0 valid held", 64'(out_valid), 64'd1);
        check("rnd0 sum held", 64'(out_sum), 64'(prev_sum));
      end
      prev_v = out_valid; prev_r = out_ready; prev_sum = out_sum;
      if (in_valid && in_ready) begin
        m0_sum = {1'b0, in_a} + {1'b0, in_b} + 33'(in_ci);
        q0.push_back({(in_a[31] == in_b[31]) && (m0_sum[31] != in_a[31]), m0_sum});
        acc0++;
      end
      if (out_valid && out_ready) begin
        res0++;
        if (q0.size() == 0) begin
          check("rnd0 unexpected result", 64'd1, 64'd0);
        end else begin
          e0 = q0.pop_front();
          check("rnd0 sum", 64'(out_sum), 64'(e0[32:0]));
          check("rnd0 ovf", 64'(out_ovf), 64'(e0[33]));
        end
      end
      if (d1_valid && d1_ready) begin
        m1_sum = {1'b0, d1_a} + {1'b0, d1_b} + 16'(d1_ci);
        q1.push_back({(d1_a[14] == d1_b[14]) && (m1_sum[14] != d1_a[14]), m1_sum});
        acc1++;
      end
      if (d1_ovalid && d1_oready) begin
        res1++;
        if (q1.size() == 0) begin
          check("rnd1 unexpected result", 64'd1, 64'd0);
        end else begin
          e1 = q1.pop_front();
          check("rnd1 sum", 64'(d1_sum), 64'(e1[15:0]));
          check("rnd1 ovf", 64'(d1_ovf), 64'(e1[16]));
        end
      end
    end
  end

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic [32:0] sum;
    logic        ovf;
  } vec_t;

  vec_t        vecs[7];
  logic [32:0] s;
  logic        o;
  int          lat;
  int          n;

  initial begin
    vecs[0] = '{"ffffffff+1",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33'h1_0000_0000, 1'b0};
    vecs[1] = '{"7fffffff+1",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 33'h0_8000_0000, 1'b1};
    vecs[2] = '{"80000000x2",  32'h8000_0000, 32'h8000_0000, 1'b0, 33'h1_0000_0000, 1'b1};
    vecs[3] = '{"zero+ci",     32'h0000_0000, 32'h0000_0000, 1'b1, 33'h0_0000_0001, 1'b0};
    vecs[4] = '{"chunk chain", 32'h00FF_00FF, 32'h0001_0001, 1'b0, 33'h0_0100_0100, 1'b0};
    vecs[5] = '{"all ones+ci", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h1_FFFF_FFFF, 1'b0};
    vecs[6] = '{"mixed",       32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 33'h0_ACF1_3568, 1'b0};

    // Reset values, observed before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset out_sum", 64'(out_sum), 64'd0);
    check("reset out_ovf", 64'(out_ovf), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].ci, s, o, lat);
      check({vecs[i].name, " sum"}, 64'(s), 64'(vecs[i].sum));
      check({vecs[i].name, " ovf"}, 64'(o), 64'(vecs[i].ovf));
      check({vecs[i].name, " latency"}, 64'(lat), 64'd4);
    end

    // Backpressure: result held while out_ready is low, new operands refused.
    @(negedge clk);
    in_valid = 1'b1; in_a = 32'd5; in_b = 32'd6; in_ci = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("bp latency", 64'(n), 64'd4);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("bp out_valid", 64'(out_valid), 64'd1);
      check("bp in_ready", 64'(in_ready), 64'd0);
      check("bp out_sum", 64'(out_sum), 64'd11);
      in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
    end
    @(negedge clk);
    check("bp out_sum end", 64'(out_sum), 64'd11);
    check("bp busy", 64'(busy), 64'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp released valid", 64'(out_valid), 64'd0);
    check("bp released in_ready", 64'(in_ready), 64'd1);

    // Asynchronous reset while the chunk index is 2.
    @(negedge clk);
    in_valid = 1'b1; in_a = 32'hFFFF_FFFF; in_b = 32'h0000_0001; in_ci = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid reset in_ready", 64'(in_ready), 64'd1);
    check("mid reset out_valid", 64'(out_valid), 64'd0);
    check("mid reset busy", 64'(busy), 64'd0);
    check("mid reset out_sum", 64'(out_sum), 64'd0);
    check("mid reset out_ovf", 64'(out_ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(32'd1, 32'd2, 1'b0, s, o, lat);
    check("post reset sum", 64'(s), 64'd3);
    check("post reset latency", 64'(lat), 64'd4);

    // Random traffic with gaps on both instances.
    rnd_on = 1'b1;
    fork
      begin
        int cyc = 0;
        while (acc0 < NR && cyc < 40000) begin
          @(posedge clk);
          #1;
          in_valid  = ($urandom_range(9) < 6);
          in_a      = $urandom;
          in_b      = $urandom;
          in_ci     = 1'($urandom_range(1));
          out_ready = ($urandom_range(9) < 7);
          cyc++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0; out_ready = 1'b1;
      end
      begin
        int cyc = 0;
        while (acc1 < NR && cyc < 40000) begin
          @(posedge clk);
          #1;
          d1_valid  = ($urandom_range(9) < 6);
          d1_a      = 15'($urandom);
          d1_b      = 15'($urandom);
          d1_ci     = 1'($urandom_range(1));
          d1_oready = ($urandom_range(9) < 7);
          cyc++;
        end
        @(posedge clk);
        #1 d1_valid = 1'b0; d1_oready = 1'b1;
      end
    join
    repeat (20) @(posedge clk);
    @(negedge clk);
    rnd_on = 1'b0;
    check("rnd0 accepts", 64'(acc0), 64'(NR));
    check("rnd0 results", 64'(res0), 64'(acc0));
    check("rnd1 accepts", 64'(acc1), 64'(NR));
    check("rnd1 results", 64'(res1), 64'(acc1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
